// File: rtl/calc_sequencer_if.sv
// Handshake and control bundle between the calculator sequencer and its environment.
//   Inputs to the sequencer:
//     Enter        raw Enter pushbutton, active-high, asynchronous
//     OpBtn        raw operation buttons, active-low; bit 0 has the highest priority
//     Done         completion from the multi-cycle unit, CLK domain
//   Outputs from the sequencer:
//     LdA / LdB    operand register loads
//     LdRes        load operand A from the result (chain mode only)
//     OP           one-hot selected operation, 0 when none is selected
//     Start        one-cycle start pulse to the multi-cycle unit
//     Busy         operation in flight
//     ResultValid  result on the datapath is valid
//     Error        sticky multi-cycle timeout flag
// The modport "master" is the sequencer side; "slave" is the datapath/panel side.
interface calc_sequencer_if #(
  parameter int unsigned N_OPS = 4
);
  logic             Enter;
  logic [N_OPS-1:0] OpBtn;
  logic             Done;
  logic             LdA;
  logic             LdB;
  logic             LdRes;
  logic [N_OPS-1:0] OP;
  logic             Start;
  logic             Busy;
  logic             ResultValid;
  logic             Error;

  modport master (
    input  Enter, OpBtn, Done,
    output LdA, LdB, LdRes, OP, Start, Busy, ResultValid, Error
  );

  modport slave (
    output Enter, OpBtn, Done,
    input  LdA, LdB, LdRes, OP, Start, Busy, ResultValid, Error
  );
endinterface

// File: rtl/calc_sequencer.sv
// Control unit for the calculator datapath. Sequences operand loads on Enter presses,
// selects an operation from the active-low op buttons, runs multi-cycle units through a
// Start/Done handshake with a tick-based timeout, then waits in RESULT for the next Enter.
// All control decisions happen on the slow internal tick (every 2^(TICK_BIT+1) CLK cycles).
// Ports:
//   CLK   system clock, posedge
//   CLR   asynchronous active-low reset
//   bus   calc_sequencer_if.master (Enter, OpBtn, Done in; LdA, LdB, LdRes, OP, Start,
//         Busy, ResultValid, Error out)
// Build option: define CALC_CHAIN_EN to let Enter in RESULT chain the result into
// operand A (goes to LOAD_B with LdRes); holding OpBtn[0] with that Enter returns to IDLE.
module calc_sequencer #(
  parameter int unsigned      TICK_BIT      = 15,
  parameter int unsigned      N_OPS         = 4,
  parameter logic [N_OPS-1:0] MC_MASK       = 4'b1100,
  parameter int unsigned      TIMEOUT_TICKS = 255
) (
  input  logic             CLK,
  input  logic             CLR,
  calc_sequencer_if.master bus
);

  localparam int unsigned SelW = $clog2(N_OPS);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoadA    = 3'd1,
    StLoadB    = 3'd2,
    StExec     = 3'd3,
    StWaitDone = 3'd4,
    StResult   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [TICK_BIT:0] tick_cnt_q;
  logic              tick;
  logic              enter_s1_q, enter_s2_q, enter_prev_q, enter_edge;
  logic [N_OPS-1:0]  op_s1_q, op_s2_q;
  logic [SelW-1:0]   sel_q, sel_d, btn_sel;
  logic              btn_any;
  logic              done_flag_q, done_seen;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic              error_q, error_d;
  logic              exec_d1_q, start_q;
  logic [N_OPS-1:0]  sel_onehot;

  assign tick       = &tick_cnt_q;
  // Enter is compared against its value on the previous tick, not the previous cycle.
  assign enter_edge = tick & enter_s2_q & ~enter_prev_q;
  // A Done arriving on the deciding tick still counts, so Done beats a same-tick timeout.
  assign done_seen  = done_flag_q | bus.Done;
  assign sel_onehot = {{(N_OPS-1){1'b0}}, 1'b1} << sel_q;

  // Lowest-index pressed (low) button wins.
  always_comb begin
    btn_sel = '0;
    btn_any = 1'b0;
    for (int i = int'(N_OPS) - 1; i >= 0; i--) begin
      if (!op_s2_q[i]) begin
        btn_sel = SelW'(i);
        btn_any = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      tick_cnt_q   <= '0;
      enter_s1_q   <= 1'b0;
      enter_s2_q   <= 1'b0;
      enter_prev_q <= 1'b0;
      op_s1_q      <= '1;  // released level, so nothing looks pressed out of reset
      op_s2_q      <= '1;
      done_flag_q  <= 1'b0;
      exec_d1_q    <= 1'b0;
      start_q      <= 1'b0;
      state_q      <= StIdle;
      sel_q        <= '0;
      to_cnt_q     <= '0;
      error_q      <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_q + 1'b1;
      enter_s1_q  <= bus.Enter;
      enter_s2_q  <= enter_s1_q;
      op_s1_q     <= bus.OpBtn;
      op_s2_q     <= op_s1_q;
      done_flag_q <= start_q ? 1'b0 : done_seen;
      exec_d1_q   <= (state_q == StExec);
      // Start fires on the cycle after the first EXEC cycle, once per EXEC visit.
      start_q     <= (state_q == StExec) && !exec_d1_q && MC_MASK[sel_q];
      if (tick) begin
        enter_prev_q <= enter_s2_q;
        state_q      <= state_d;
        sel_q        <= sel_d;
        to_cnt_q     <= to_cnt_d;
        error_q      <= error_d;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    to_cnt_d = to_cnt_q;
    error_d  = error_q;
    case (state_q)
      StIdle:  if (enter_edge) state_d = StLoadA;
      StLoadA: if (enter_edge) state_d = StLoadB;
      StLoadB: begin
        if (btn_any) begin
          state_d = StExec;
          sel_d   = btn_sel;
        end
      end
      StExec: begin
        to_cnt_d = '0;
        state_d  = MC_MASK[sel_q] ? StWaitDone : StResult;
      end
      StWaitDone: begin
        if (done_seen) begin
          state_d = StResult;
        end else if (to_cnt_q + 8'd1 == 8'(TIMEOUT_TICKS)) begin
          state_d = StResult;
          error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      StResult: begin
        if (enter_edge) begin
          error_d = 1'b0;
`ifdef CALC_CHAIN_EN
          state_d = op_s2_q[0] ? StLoadB : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        error_d = 1'b0;
      end
    endcase
  end

`ifdef CALC_CHAIN_EN
  // Marks a LOAD_B visit that was entered by chaining from RESULT.
  logic chain_q, chain_d;

  always_comb begin
    chain_d = chain_q;
    if (state_q == StResult && enter_edge && op_s2_q[0]) begin
      chain_d = 1'b1;
    end else if (state_q != StLoadB) begin
      chain_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      chain_q <= 1'b0;
    end else if (tick) begin
      chain_q <= chain_d;
    end
  end

  assign bus.LdRes = chain_q && (state_q == StLoadB);
`else
  assign bus.LdRes = 1'b0;
`endif

  assign bus.Start = start_q;
  assign bus.Error = error_q;

  always_comb begin
    bus.LdA         = 1'b0;
    bus.LdB         = 1'b0;
    bus.OP          = '0;
    bus.Busy        = 1'b0;
    bus.ResultValid = 1'b0;
    case (state_q)
      StLoadA: bus.LdA = 1'b1;
      StLoadB: bus.LdB = 1'b1;
      StExec, StWaitDone: begin
        bus.OP   = sel_onehot;
        bus.Busy = 1'b1;
      end
      StResult: begin
        bus.OP          = sel_onehot;
        bus.ResultValid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer with a fast tick (TICK_BIT=1, tick every 4 cycles) and a
// 3-tick timeout. Expected results are queued when an operation is selected and popped
// when ResultValid rises.
module tb_calc_sequencer;
  localparam int unsigned NOps = 4;

  logic CLK = 1'b0;
  logic CLR = 1'b0;

  calc_sequencer_if #(.N_OPS(NOps)) bus ();

  calc_sequencer #(
    .TICK_BIT     (1),
    .N_OPS        (NOps),
    .MC_MASK      (4'b1100),
    .TIMEOUT_TICKS(3)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned start_cnt   = 0;
  int unsigned busy_cnt    = 0;

  typedef struct packed {
    logic [NOps-1:0] op;
    logic            err;
  } exp_t;

  exp_t sb[$];
  exp_t sb_exp;
  logic rv_prev = 1'b0;

  function automatic logic [NOps+6:0] outs();
    return {bus.LdA, bus.LdB, bus.LdRes, bus.OP, bus.Start, bus.Busy, bus.ResultValid,
            bus.Error};
  endfunction

  always @(negedge CLK) begin
    if (bus.Start) start_cnt++;
    if (bus.Busy) busy_cnt++;
  end

  // Scoreboard: each rising ResultValid consumes one expected {OP, Error}.
  always @(negedge CLK) begin
    if (bus.ResultValid && !rv_prev) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: result OP=%b Error=%b with no queued expectation",
                 bus.OP, bus.Error);
      end else begin
        sb_exp = sb.pop_front();
        if ({bus.OP, bus.Error} !== sb_exp) begin
          miscompares++;
          $display("FAIL sb_result: OP=%b Error=%b, expected OP=%b Error=%b",
                   bus.OP, bus.Error, sb_exp.op, sb_exp.err);
        end
      end
    end
    rv_prev = bus.ResultValid;
  end

  // Enter held and released long enough that ticks see both levels.
  task automatic press_enter();
    bus.Enter = 1'b1;
    repeat (12) @(negedge CLK);
    bus.Enter = 1'b0;
    repeat (12) @(negedge CLK);
  endtask

  // which: 0 = ResultValid, 1 = Busy, 2 = Start. cycles = negedges until seen.
  task automatic wait_out(input int which, input int limit, output int cycles, output bit ok);
    ok     = 1'b0;
    cycles = 0;
    while (cycles < limit && !ok) begin
      @(negedge CLK);
      cycles++;
      case (which)
        0:       ok = bus.ResultValid;
        1:       ok = bus.Busy;
        2:       ok = bus.Start;
        default: ok = 1'b0;
      endcase
    end
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs=%b, expected all 0", outs());
    end
    CLR = 1'b1;
    repeat (40) @(negedge CLK);
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: outputs=%b, expected all 0", outs());
    end
  endtask

  task automatic test_add();
    int cyc;
    bit ok;
    press_enter();
    vectors++;
    if ({bus.LdA, bus.LdB} !== 2'b10) begin
      miscompares++;
      $display("FAIL add_load_a: LdA,LdB=%b, expected 10", {bus.LdA, bus.LdB});
    end
    press_enter();
    vectors++;
    if ({bus.LdA, bus.LdB} !== 2'b01) begin
      miscompares++;
      $display("FAIL add_load_b: LdA,LdB=%b, expected 01", {bus.LdA, bus.LdB});
    end
    start_cnt = 0;
    sb.push_back({4'b0001, 1'b0});
    bus.OpBtn = 4'b1110;
    wait_out(1, 40, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL add_busy: Busy not seen within %0d cycles, expected it", cyc);
    end
    wait_out(0, 40, cyc, ok);
    vectors++;
    if (!ok || cyc != 4) begin
      miscompares++;
      $display("FAIL add_exec_len: ResultValid seen=%0b after %0d cycles, expected 1 after 4",
               ok, cyc);
    end
    bus.OpBtn = 4'b1111;
    vectors++;
    if (start_cnt != 0) begin
      miscompares++;
      $display("FAIL add_no_start: Start cycles=%0d, expected 0", start_cnt);
    end
    press_enter();
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL add_back_idle: outputs=%b, expected all 0", outs());
    end
  endtask

  task automatic test_mul();
    int cyc;
    bit ok;
    press_enter();
    press_enter();
    start_cnt = 0;
    busy_cnt  = 0;
    sb.push_back({4'b0100, 1'b0});
    bus.OpBtn = 4'b1011;
    wait_out(2, 60, cyc, ok);
    vectors++;
    if (!ok || bus.Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_start: Start seen=%0b Busy=%b, expected 1 and 1", ok, bus.Busy);
    end
    bus.OpBtn = 4'b1111;
    repeat (9) @(negedge CLK);
    bus.Done = 1'b1;
    @(negedge CLK);
    bus.Done = 1'b0;
    wait_out(0, 60, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL mul_result: ResultValid not seen in %0d cycles, expected it", cyc);
    end
    vectors++;
    if (start_cnt != 1) begin
      miscompares++;
      $display("FAIL mul_start_len: Start cycles=%0d, expected 1", start_cnt);
    end
    vectors++;
    if (busy_cnt != 12) begin
      miscompares++;
      $display("FAIL mul_busy_len: Busy cycles=%0d, expected 12", busy_cnt);
    end
    press_enter();
  endtask

  task automatic test_timeout();
    int cyc;
    bit ok;
    press_enter();
    press_enter();
    sb.push_back({4'b1000, 1'b1});
    bus.OpBtn = 4'b0111;
    wait_out(1, 40, cyc, ok);
    bus.OpBtn = 4'b1111;
    wait_out(0, 40, cyc, ok);
    vectors++;
    if (!ok || cyc != 16) begin
      miscompares++;
      $display("FAIL timeout_len: ResultValid seen=%0b after %0d cycles, expected 1 after 16",
               ok, cyc);
    end
    vectors++;
    if ({bus.Error, bus.ResultValid, bus.Busy} !== 3'b110) begin
      miscompares++;
      $display("FAIL timeout_flags: Error,RV,Busy=%b, expected 110",
               {bus.Error, bus.ResultValid, bus.Busy});
    end
    press_enter();
    vectors++;
    if ({bus.Error, bus.ResultValid} !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_clear: Error,RV=%b, expected 00", {bus.Error, bus.ResultValid});
    end
  endtask

  task automatic test_priority_reset();
    int cyc;
    bit ok;
    press_enter();
    press_enter();
    sb.push_back({4'b0001, 1'b0});
    bus.OpBtn = 4'b0100;
    wait_out(0, 60, cyc, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL prio_result: ResultValid not seen in %0d cycles, expected it", cyc);
    end
    bus.OpBtn = 4'b1111;
    press_enter();
    press_enter();
    press_enter();
    bus.OpBtn = 4'b1011;
    wait_out(2, 60, cyc, ok);
    bus.OpBtn = 4'b1111;
    repeat (6) @(negedge CLK);
    vectors++;
    if (bus.Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_pre_busy: Busy=%b, expected 1 in WAIT_DONE", bus.Busy);
    end
    CLR = 1'b0;
    #1;
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL clr_async: outputs=%b, expected all 0", outs());
    end
    @(negedge CLK);
    CLR = 1'b1;
    repeat (10) @(negedge CLK);
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL clr_after: outputs=%b, expected all 0", outs());
    end
    press_enter();
    vectors++;
    if ({bus.LdA, bus.LdB} !== 2'b10) begin
      miscompares++;
      $display("FAIL clr_idle: LdA,LdB=%b, expected 10 after one Enter", {bus.LdA, bus.LdB});
    end
    CLR = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_chain();
    int cyc;
    bit ok;
    press_enter();
    press_enter();
    sb.push_back({4'b0001, 1'b0});
    bus.OpBtn = 4'b1110;
    wait_out(0, 60, cyc, ok);
    bus.OpBtn = 4'b1111;
    press_enter();
`ifdef CALC_CHAIN_EN
    vectors++;
    if ({bus.LdA, bus.LdB, bus.LdRes, bus.ResultValid} !== 4'b0110) begin
      miscompares++;
      $display("FAIL chain_load: LdA,LdB,LdRes,RV=%b, expected 0110",
               {bus.LdA, bus.LdB, bus.LdRes, bus.ResultValid});
    end
    sb.push_back({4'b0010, 1'b0});
    bus.OpBtn = 4'b1101;
    wait_out(0, 60, cyc, ok);
    vectors++;
    if (!ok || bus.LdRes !== 1'b0) begin
      miscompares++;
      $display("FAIL chain_result: RV seen=%0b LdRes=%b, expected 1 and 0", ok, bus.LdRes);
    end
    bus.OpBtn = 4'b1110;
    press_enter();
    bus.OpBtn = 4'b1111;
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL chain_exit: outputs=%b, expected all 0 after Enter with OpBtn[0]", outs());
    end
`else
    vectors++;
    if ({bus.LdA, bus.LdB, bus.LdRes, bus.ResultValid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL nochain_idle: LdA,LdB,LdRes,RV=%b, expected 0000",
               {bus.LdA, bus.LdB, bus.LdRes, bus.ResultValid});
    end
`endif
  endtask

  initial begin
    bus.Enter = 1'b0;
    bus.OpBtn = 4'b1111;
    bus.Done  = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_timeout();
    test_priority_reset();
    test_chain();
    repeat (4) @(negedge CLK);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d expected results never produced, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
